// File: rtl/sd_req_arbiter.sv
// Round-robin arbiter sharing the user_io sector channel between two requesters.
// Optional grant timeout enabled by defining SD_REQ_ARB_TIMEOUT_EN.
module sd_req_arbiter #(
  parameter int unsigned TO_BITS = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req_lba0,
  input  logic [31:0] req_lba1,
  input  logic [7:0]  req_din0,
  input  logic [7:0]  req_din1,
  output logic [1:0]  req_ack,
  output logic [1:0]  req_dout_strobe,
  output logic [1:0]  req_din_strobe,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  output logic [7:0]  sd_din,
  input  logic        sd_ack,
  input  logic        sd_dout_strobe,
  input  logic        sd_din_strobe
);

  typedef enum logic [1:0] {StIdle, StReq, StXfer, StRel} state_e;

  state_e     state_q;
  logic       grant_q;
  logic       last_q;
  logic [1:0] pending;
  logic       win;
  logic       active;

  assign pending = req_rd | req_wr;
  // The requester not served last has priority; otherwise the other one is taken.
  assign win     = pending[~last_q] ? ~last_q : last_q;
  assign active  = (state_q == StReq) || (state_q == StXfer);

`ifdef SD_REQ_ARB_TIMEOUT_EN
  // Timeout fires on the cycle the count would reach 2**TO_BITS-1.
  localparam logic [TO_BITS-1:0] ToLast = {{(TO_BITS-1){1'b1}}, 1'b0};

  logic [TO_BITS-1:0] to_cnt_q;
  logic [1:0]         req_err_q;

  assign req_err = req_err_q;
`else
  logic unused_to_bits;

  assign unused_to_bits = ^TO_BITS;
  assign req_err        = '0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;
      sd_lba   <= '0;
      sd_rd    <= 1'b0;
      sd_wr    <= 1'b0;
      req_done <= '0;
`ifdef SD_REQ_ARB_TIMEOUT_EN
      to_cnt_q  <= '0;
      req_err_q <= '0;
`endif
    end else begin
      req_done <= '0;
`ifdef SD_REQ_ARB_TIMEOUT_EN
      req_err_q <= '0;
`endif
      unique case (state_q)
        StIdle: begin
          if (|pending) begin
            grant_q <= win;
            sd_lba  <= win ? req_lba1 : req_lba0;
            sd_rd   <= req_rd[win];
            sd_wr   <= ~req_rd[win];
            state_q <= StReq;
`ifdef SD_REQ_ARB_TIMEOUT_EN
            to_cnt_q <= '0;
`endif
          end
        end
        StReq: begin
          if (sd_ack) begin
            sd_rd   <= 1'b0;
            sd_wr   <= 1'b0;
            state_q <= StXfer;
          end
`ifdef SD_REQ_ARB_TIMEOUT_EN
          else if (to_cnt_q == ToLast) begin
            sd_rd              <= 1'b0;
            sd_wr              <= 1'b0;
            req_err_q[grant_q] <= 1'b1;
            last_q             <= grant_q;
            state_q            <= StIdle;
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
`endif
        end
        StXfer: begin
          if (!sd_ack) begin
            req_done[grant_q] <= 1'b1;
            state_q           <= StRel;
          end
        end
        StRel: begin
          last_q  <= grant_q;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    req_ack         = '0;
    req_dout_strobe = '0;
    req_din_strobe  = '0;
    sd_din          = '0;
    if (active) begin
      req_ack[grant_q]         = sd_ack;
      req_dout_strobe[grant_q] = sd_dout_strobe;
      req_din_strobe[grant_q]  = sd_din_strobe;
      sd_din                   = grant_q ? req_din1 : req_din0;
    end
  end

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Self-checking bench for sd_req_arbiter: directed scenarios plus randomized transactions
// checked against a round-robin reference model.
module tb_sd_req_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req_lba0, req_lba1;
  logic [7:0]  req_din0, req_din1;
  logic [1:0]  req_ack, req_dout_strobe, req_din_strobe, req_done, req_err;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic [7:0]  sd_din;
  logic        sd_ack, sd_dout_strobe, sd_din_strobe;

  always #5 clk = ~clk;

  sd_req_arbiter #(.TO_BITS(4)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .req_rd          (req_rd),
    .req_wr          (req_wr),
    .req_lba0        (req_lba0),
    .req_lba1        (req_lba1),
    .req_din0        (req_din0),
    .req_din1        (req_din1),
    .req_ack         (req_ack),
    .req_dout_strobe (req_dout_strobe),
    .req_din_strobe  (req_din_strobe),
    .req_done        (req_done),
    .req_err         (req_err),
    .sd_lba          (sd_lba),
    .sd_rd           (sd_rd),
    .sd_wr           (sd_wr),
    .sd_din          (sd_din),
    .sd_ack          (sd_ack),
    .sd_dout_strobe  (sd_dout_strobe),
    .sd_din_strobe   (sd_din_strobe)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_last;  // model: requester served most recently

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Round robin: try the requester not served last, then the one that was.
  function automatic int pick(input logic [1:0] pend, input int last);
    int order [2];
    order[0] = 1 - last;
    order[1] = last;
    for (int i = 0; i < 2; i++) if (pend[order[i]]) return order[i];
    return -1;
  endfunction

  // One complete transfer starting in IDLE with requests already presented.
  // drop: 0 keep request, 1 drop on ack, 2 withdraw during REQ.
  task automatic run_xfer(input int d, input int k, input int drop);
    int          g;
    logic        exp_rd, s1, s2;
    logic [1:0]  gm;
    logic [31:0] exp_lba;
    g = pick(req_rd | req_wr, m_last);
    if (g < 0) begin
      n_fail++;
      $display("FAIL run_xfer: no request pending");
      return;
    end
    gm      = 2'b01 << g;
    exp_rd  = req_rd[g];
    exp_lba = (g == 1) ? req_lba1 : req_lba0;
    tick();
    chk("grant_rdwr", {30'd0, sd_rd, sd_wr}, {30'd0, exp_rd, ~exp_rd});
    chk("grant_lba", sd_lba, exp_lba);
    chk("ack_pre", {30'd0, req_ack}, 0);
    if (drop == 2) begin
      req_rd[g] = 1'b0;
      req_wr[g] = 1'b0;
    end
    repeat (d) begin
      tick();
      chk("hold_rdwr", {30'd0, sd_rd, sd_wr}, {30'd0, exp_rd, ~exp_rd});
    end
    sd_ack = 1'b1;
    #1;
    chk("ack_route", {30'd0, req_ack}, {30'd0, gm});
    if (drop == 1) begin
      req_rd[g] = 1'b0;
      req_wr[g] = 1'b0;
    end
    if (g == 1) req_lba1 = $urandom; else req_lba0 = $urandom;
    tick();
    chk("ack_drop_rdwr", {30'd0, sd_rd, sd_wr}, 0);
    for (int i = 0; i < k; i++) begin
      s1 = 1'($urandom_range(0, 1));
      s2 = 1'($urandom_range(0, 1));
      sd_dout_strobe = s1;
      sd_din_strobe  = s2;
      #1;
      chk("dout_strobe", {30'd0, req_dout_strobe}, s1 ? {30'd0, gm} : 32'd0);
      chk("din_strobe", {30'd0, req_din_strobe}, s2 ? {30'd0, gm} : 32'd0);
      chk("sd_din", {24'd0, sd_din}, {24'd0, (g == 1) ? req_din1 : req_din0});
      chk("lba_stable", sd_lba, exp_lba);
      tick();
      sd_dout_strobe = 1'b0;
      sd_din_strobe  = 1'b0;
    end
    sd_ack = 1'b0;
    tick();
    chk("done_pulse", {30'd0, req_done}, {30'd0, gm});
    chk("ack_off", {30'd0, req_ack}, 0);
    chk("err_none", {30'd0, req_err}, 0);
    m_last = g;
    tick();
    chk("done_clear", {30'd0, req_done}, 0);
    chk("idle_gap", {30'd0, sd_rd, sd_wr}, 0);
  endtask

  initial begin
    reset_n = 1'b0;
    req_rd = '0; req_wr = '0; req_lba0 = '0; req_lba1 = '0;
    req_din0 = '0; req_din1 = '0;
    sd_ack = 1'b0; sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
    m_last = 1;

    // Reset state
    repeat (3) tick();
    chk("rst_rdwr", {30'd0, sd_rd, sd_wr}, 0);
    chk("rst_lba", sd_lba, 0);
    chk("rst_done", {30'd0, req_done}, 0);
    chk("rst_err", {30'd0, req_err}, 0);
    chk("rst_ack", {30'd0, req_ack}, 0);
    chk("rst_din", {24'd0, sd_din}, 0);
    reset_n = 1'b1;

    // Single read from requester 0
    req_rd = 2'b01; req_lba0 = 32'h100;
    run_xfer(0, 4, 1);

    // Stale ack in IDLE is not forwarded and grants nothing
    sd_ack = 1'b1;
    #1;
    chk("stale_ack", {30'd0, req_ack}, 0);
    tick();
    chk("stale_rdwr", {30'd0, sd_rd, sd_wr}, 0);
    chk("stale_done", {30'd0, req_done}, 0);
    sd_ack = 1'b0;
    tick();

    // Both requesters held: grants alternate
    req_rd = 2'b11; req_lba0 = 32'hAAAA_0000; req_lba1 = 32'hBBBB_0000;
    repeat (3) run_xfer(1, 2, 0);
    req_rd = 2'b00;

    // Write from requester 1, din muxing
    req_wr = 2'b10; req_din1 = 8'hA5; req_din0 = 8'h3C; req_lba1 = 32'h55;
    run_xfer(1, 4, 1);

    // Reset during XFER aborts; afterwards requester 0 wins a tie
    req_rd = 2'b01;
    tick();
    sd_ack = 1'b1;
    tick();
    reset_n = 1'b0;
    tick();
    chk("abort_rdwr", {30'd0, sd_rd, sd_wr}, 0);
    chk("abort_done", {30'd0, req_done}, 0);
    chk("abort_ack", {30'd0, req_ack}, 0);
    reset_n = 1'b1; sd_ack = 1'b0; req_rd = 2'b11; m_last = 1;
    run_xfer(0, 2, 1);
    req_rd = 2'b00;

    // Grant with no sd_ack
    req_rd = 2'b01; req_lba0 = 32'h777;
    tick();
    chk("to_grant", {31'd0, sd_rd}, 1);
`ifdef SD_REQ_ARB_TIMEOUT_EN
    repeat (14) begin
      tick();
      chk("to_hold", {31'd0, sd_rd}, 1);
    end
    tick();
    chk("to_drop", {30'd0, sd_rd, sd_wr}, 0);
    chk("to_err", {30'd0, req_err}, 32'd1);
    chk("to_nodone", {30'd0, req_done}, 0);
    req_rd = 2'b00;
    m_last = 0;
    tick();
    chk("to_err_clear", {30'd0, req_err}, 0);
`else
    repeat (100) begin
      tick();
      chk("no_to_hold", {31'd0, sd_rd}, 1);
    end
    chk("no_to_err", {30'd0, req_err}, 0);
    sd_ack = 1'b1;
    tick();
    req_rd = 2'b00; sd_ack = 1'b0;
    tick();
    chk("no_to_done", {30'd0, req_done}, 32'd1);
    m_last = 0;
    tick();
`endif

    // Randomized transactions against the model
    for (int t = 0; t < 40; t++) begin
      for (int r = 0; r < 2; r++) begin
        if (!(req_rd[r] | req_wr[r]) && $urandom_range(0, 1) == 1) begin
          req_rd[r] = 1'($urandom_range(0, 1));
          req_wr[r] = ~req_rd[r] | 1'($urandom_range(0, 1));
          if (r == 1) req_lba1 = $urandom; else req_lba0 = $urandom;
        end
      end
      if ((req_rd | req_wr) == 2'b00) req_wr[$urandom_range(0, 1)] = 1'b1;
      req_din0 = 8'($urandom);
      req_din1 = 8'($urandom);
      run_xfer($urandom_range(0, 3), $urandom_range(0, 4), $urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
